// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and the line-index helper for the line responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;

    // Callers keep only the low $clog2(DEPTH) bits, so upper address bits wrap away.
    function automatic logic [63:0] line_index(input logic [63:0] addr);
        return addr >> OFFSET_BITS;
    endfunction

endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: single-port DEPTH x WIDTH line store, synchronous write, registered read.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = LINE_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) r_mem[idx_i] <= wdata_i;
    end

    // Only the read register is reset; the storage itself keeps its contents.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_o <= '0;
        else if (re_i) rdata_o <= r_mem[idx_i];
    end

endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: fixed-latency responder for the dcache 256-bit line handshake.
// Define DMEM_PROTO_CHECK_EN to enable the sticky protocol checker on err_o.
module dmem_line_responder #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    parameter int LINE_W  = dmem_pkg::LINE_W,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              err_o
);

    import dmem_pkg::*;

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int IDX_W = $clog2(DEPTH);

    state_t            r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]  r_idx, w_idx_live, w_idx;
    logic              r_write, w_commit, w_live, w_wr, w_we, w_re;
    logic [LINE_W-1:0] r_data, w_wdata;
    logic [63:0]       w_line;
    logic              w_unused;

    assign w_line     = line_index(64'(addr_i));
    assign w_idx_live = w_line[IDX_W-1:0];
    assign w_unused   = ^w_line[63:IDX_W];

    // Counter runs LATENCY-1 down to 0 so ACK is entered LATENCY edges after accept.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_commit   = 1'b0;
        case (r_state)
            IDLE: if (enable_i) begin
                w_cnt_nx   = CNT_W'(LATENCY - 1);
                w_state_nx = (LATENCY == 1) ? ACK : BUSY;
                w_commit   = (LATENCY == 1);
            end
            BUSY: if (r_cnt == '0) begin
                w_state_nx = ACK;
                w_commit   = 1'b1;
            end else begin
                w_cnt_nx = r_cnt - 1'b1;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // With LATENCY=1 the commit coincides with accept, so the live request is used.
    assign w_live  = (r_state == IDLE);
    assign w_idx   = w_live ? w_idx_live : r_idx;
    assign w_wr    = w_live ? write_i : r_write;
    assign w_wdata = w_live ? data_i : r_data;
    assign w_we    = w_commit & w_wr;
    assign w_re    = w_commit & ~w_wr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_live && enable_i) begin
                r_idx   <= w_idx_live;
                r_write <= write_i;
                r_data  <= data_i;
            end
        end
    end

    assign ack_o = (r_state == ACK);

    dmem_line_array #(
        .DEPTH (DEPTH),
        .WIDTH (LINE_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_we),
        .re_i    (w_re),
        .idx_i   (w_idx),
        .wdata_i (w_wdata),
        .rdata_o (data_o)
    );

`ifdef DMEM_PROTO_CHECK_EN
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    // Observation only: the checker never feeds back into the datapath or handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_live && enable_i) r_addr <= addr_i;
            if (r_state == BUSY && (!enable_i || addr_i != r_addr || write_i != r_write ||
                                    (write_i && data_i != r_data)))
                r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule
